// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmit frame engine. Serialises one character per
//            handshake as start, 5..9 data bits LSB first, optional even
//            parity, and one or two stop bits, timed by a bit-period divider.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  divider,
  input  logic                  en_tx,
  input  logic [4:0]            frame_len,
  input  logic                  parity,
  input  logic                  dstop,
  input  logic                  flow_control,
  input  logic                  cts_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  // ST_DATA covers D1..D9; the current data bit index lives in bit_q.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DSTOP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  dstop_q, dstop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic [3:0]            len_clamped;
  logic [DATA_WIDTH-1:0] len_mask;
  logic                  bit_end;
  logic                  accept;

  // Clamp the requested frame length into the legal 5..9 range.
  always_comb begin
    if (frame_len < 5'd5)      len_clamped = 4'd5;
    else if (frame_len > 5'd9) len_clamped = 4'd9;
    else                       len_clamped = frame_len[3:0];
  end

  // Keep only the data bits that will actually be sent, so parity is a plain XOR.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      len_mask[i] = (i < int'(len_clamped));
    end
  end

  assign s_ready = (state_q == ST_IDLE) && en_tx && (!flow_control || !cts_n);
  assign accept  = s_valid && s_ready;
  assign bit_end = (cnt_q == div_q);

  // Next-state, frame parameter capture and next tx level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    len_d   = len_q;
    bit_d   = bit_q;
    par_d   = par_q;
    dstop_d = dstop_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_START;
        cnt_d   = '0;
        bit_d   = '0;
        div_d   = divider;
        len_d   = len_clamped;
        par_d   = parity;
        dstop_d = dstop;
        data_d  = s_data & len_mask;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
        ST_DATA: begin
          if (bit_q == len_q - 4'd1) state_d = par_q ? ST_PARITY : ST_STOP;
          else                       bit_d   = bit_q + 4'd1;
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          if (dstop_q) begin
            state_d = ST_DSTOP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_DSTOP: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
      ST_PARITY: tx_d = ^data_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle-high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= 4'd5;
      bit_q   <= '0;
      par_q   <= 1'b0;
      dstop_q <= 1'b0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      dstop_q <= dstop_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;

endmodule
`default_nettype wire
